// File: rtl/uart_line_tx_if.sv
// uart_line_tx_if
// Groups the line-request handshake (START/DATA/BUSY/DONE) and the
// character handshake to the UART core (TXSTART/TXDATA/TXBUSY/TXDONE).
//   master : the environment side. It requests lines and also plays the
//            UART core, so it drives START, DATA, TXBUSY and TXDONE.
//   slave  : the line transmitter. It drives BUSY, DONE, TXSTART and TXDATA.
interface uart_line_tx_if #(
   parameter int DWIDTH = 32
);
   logic              START;
   logic [DWIDTH-1:0] DATA;
   logic              BUSY;
   logic              DONE;
   logic              TXSTART;
   logic [7:0]        TXDATA;
   logic              TXBUSY;
   logic              TXDONE;

   modport master (
      output START, DATA, TXBUSY, TXDONE,
      input  BUSY, DONE, TXSTART, TXDATA
   );

   modport slave (
      input  START, DATA, TXBUSY, TXDONE,
      output BUSY, DONE, TXSTART, TXDATA
   );
endinterface

// File: rtl/uart_line_tx.sv
// uart_line_tx
// Sends one DWIDTH-bit word as a text line to a UART core. The word is
// emitted most-significant first, either as uppercase ASCII hex digits
// (HEX=1) or as raw bytes (HEX=0). An optional CR (CRLF=1) and a
// terminating LF follow. Each character is handed to the UART core with a
// one-cycle TXSTART and then the module waits for TXDONE.
// Ports:
//   CLOCK   system clock, rising edge
//   NRESET  asynchronous active-low reset
//   bus     uart_line_tx_if.slave:
//             START/DATA in   line request and payload
//             BUSY/DONE  out  line in progress / one-cycle completion pulse
//             TXSTART/TXDATA out  character request to the UART core
//             TXBUSY/TXDONE  in   UART core busy / end-of-character pulse
module uart_line_tx #(
   parameter int DWIDTH = 32,
   parameter bit HEX    = 1'b1,
   parameter bit CRLF   = 1'b1
) (
   input  logic           CLOCK,
   input  logic           NRESET,
   uart_line_tx_if.slave  bus
);

   localparam int NP   = HEX ? DWIDTH / 4 : DWIDTH / 8;
   localparam int NT   = CRLF ? 2 : 1;
   localparam int N    = NP + NT;
   localparam int IW   = $clog2(N + 1);
   localparam int STEP = HEX ? 4 : 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t            state_reg;
   logic [DWIDTH-1:0] shift_reg;
   logic [IW-1:0]     index_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              txstart_reg;
   logic [7:0]        txdata_reg;

   logic [3:0]        nibble_val;
   logic [7:0]        hex_char;
   logic [7:0]        cur_char;

   // Character for the current index. The payload always sits at the top
   // of the shift register, so only the index decides payload vs CR/LF.
   always_comb begin
      nibble_val = shift_reg[DWIDTH-1 -: 4];
      hex_char   = (nibble_val < 4'd10) ? (8'h30 + {4'h0, nibble_val})
                                        : (8'h37 + {4'h0, nibble_val});
      cur_char   = 8'h0A;
      if (index_reg < IW'(NP)) begin
         cur_char = HEX ? hex_char : shift_reg[DWIDTH-1 -: 8];
      end else if (CRLF && (index_reg == IW'(NP))) begin
         cur_char = 8'h0D;
      end
   end

   always_ff @(posedge CLOCK or negedge NRESET) begin
      if (!NRESET) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         index_reg   <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         txstart_reg <= 1'b0;
         txdata_reg  <= 8'h00;
      end else begin
         // Both pulses last exactly one cycle unless re-armed below.
         txstart_reg <= 1'b0;
         done_reg    <= 1'b0;
         case (state_reg)
            IDLE: begin
               // BUSY stays high through the DONE cycle and drops here,
               // unless a new line is accepted on this very edge.
               busy_reg <= 1'b0;
               if (bus.START) begin
                  shift_reg <= bus.DATA;
                  index_reg <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= ISSUE;
               end
            end
            ISSUE: begin
               if (!bus.TXBUSY) begin
                  txdata_reg  <= cur_char;
                  txstart_reg <= 1'b1;
                  shift_reg   <= shift_reg << STEP;
                  state_reg   <= WAIT;
               end
            end
            WAIT: begin
               if (bus.TXDONE) begin
                  index_reg <= index_reg + IW'(1);
                  state_reg <= (index_reg == IW'(N - 1)) ? FIN : ISSUE;
               end
            end
            FIN: begin
               done_reg  <= 1'b1;
               state_reg <= IDLE;
            end
            default: begin
               state_reg   <= IDLE;
               shift_reg   <= '0;
               index_reg   <= '0;
               busy_reg    <= 1'b0;
               done_reg    <= 1'b0;
               txstart_reg <= 1'b0;
               txdata_reg  <= 8'h00;
            end
         endcase
      end
   end

   assign bus.BUSY    = busy_reg;
   assign bus.DONE    = done_reg;
   assign bus.TXSTART = txstart_reg;
   assign bus.TXDATA  = txdata_reg;

endmodule

// File: tb/tb_uart_line_tx.sv
// tb_uart_line_tx
// Drives two transmitters (HEX/CRLF and raw/LF-only) against a simple
// UART core model answering TXDONE 20 cycles after each TXSTART, and
// compares the emitted character stream with a reference built from the
// payload with plain arithmetic.
module tb_uart_line_tx;

   logic clock  = 1'b0;
   logic nreset = 1'b0;
   always #5 clock = ~clock;

   uart_line_tx_if #(.DWIDTH(32)) bh ();
   uart_line_tx_if #(.DWIDTH(32)) br ();

   uart_line_tx #(.DWIDTH(32), .HEX(1'b1), .CRLF(1'b1)) dut_h (
      .CLOCK (clock),
      .NRESET(nreset),
      .bus   (bh)
   );

   uart_line_tx #(.DWIDTH(32), .HEX(1'b0), .CRLF(1'b0)) dut_r (
      .CLOCK (clock),
      .NRESET(nreset),
      .bus   (br)
   );

   int checks   = 0;
   int failures = 0;

   // UART core models
   int   cnt_h = 0, cnt_r = 0;
   logic mbusy_h = 1'b0, mdone_h = 1'b0, hold_h = 1'b0;
   logic mbusy_r = 1'b0, mdone_r = 1'b0;
   assign bh.TXBUSY = mbusy_h | hold_h;
   assign bh.TXDONE = mdone_h;
   assign br.TXBUSY = mbusy_r;
   assign br.TXDONE = mdone_r;

   always @(negedge clock) begin
      mdone_h = 1'b0;
      if (!nreset) begin
         cnt_h = 0; mbusy_h = 1'b0;
      end else if (bh.TXSTART) begin
         cnt_h = 20; mbusy_h = 1'b1;
      end else if (cnt_h > 0) begin
         cnt_h--;
         if (cnt_h == 0) begin mdone_h = 1'b1; mbusy_h = 1'b0; end
      end
   end

   always @(negedge clock) begin
      mdone_r = 1'b0;
      if (!nreset) begin
         cnt_r = 0; mbusy_r = 1'b0;
      end else if (br.TXSTART) begin
         cnt_r = 20; mbusy_r = 1'b1;
      end else if (cnt_r > 0) begin
         cnt_r--;
         if (cnt_r == 0) begin mdone_r = 1'b1; mbusy_r = 1'b0; end
      end
   end

   // Monitors: record characters, DONE pulses and protocol violations
   logic [7:0] q_h[$], q_r[$];
   logic [7:0] last_h = 8'h00, last_r = 8'h00;
   logic       prev_ts_h = 1'b0, prev_ts_r = 1'b0;
   int         done_h = 0, done_r = 0, dbl_h = 0, dbl_r = 0, unst_h = 0, unst_r = 0;

   always @(negedge clock) begin
      if (!nreset) begin
         last_h = 8'h00;
      end else begin
         if (bh.TXSTART) begin
            if (prev_ts_h) dbl_h++;
            q_h.push_back(bh.TXDATA);
            last_h = bh.TXDATA;
         end else if (bh.TXDATA !== last_h) begin
            unst_h++;
         end
         if (bh.DONE) done_h++;
      end
      prev_ts_h = bh.TXSTART;
   end

   always @(negedge clock) begin
      if (!nreset) begin
         last_r = 8'h00;
      end else begin
         if (br.TXSTART) begin
            if (prev_ts_r) dbl_r++;
            q_r.push_back(br.TXDATA);
            last_r = br.TXDATA;
         end else if (br.TXDATA !== last_r) begin
            unst_r++;
         end
         if (br.DONE) done_r++;
      end
      prev_ts_r = br.TXSTART;
   end

   int         base_h = 0, base_r = 0, dbase_h = 0, dbase_r = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference line: payload digits/bytes MSB first, then CR?, LF.
   function automatic void build_expected(input bit hex, input bit crlf, input logic [31:0] d);
      exp_q.delete();
      if (hex) begin
         for (int i = 0; i < 8; i++) begin
            int n;
            n = int'((d >> (28 - 4 * i)) & 32'hF);
            exp_q.push_back((n < 10) ? 8'(48 + n) : 8'(65 + n - 10));
         end
      end else begin
         for (int i = 0; i < 4; i++) exp_q.push_back(8'((d >> (24 - 8 * i)) & 32'hFF));
      end
      if (crlf) exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endfunction

   task automatic mark(input bit sel);
      if (sel) begin base_r = q_r.size(); dbase_r = done_r; end
      else     begin base_h = q_h.size(); dbase_h = done_h; end
   endtask

   task automatic start_line(input bit sel, input logic [31:0] d);
      @(negedge clock); #1;
      mark(sel);
      if (sel) begin br.START = 1'b1; br.DATA = d; end
      else     begin bh.START = 1'b1; bh.DATA = d; end
      @(negedge clock); #1;
      br.START = 1'b0;
      bh.START = 1'b0;
   endtask

   task automatic wait_done(input bit sel, input string tag);
      logic found;
      found = 1'b0;
      for (int c = 0; c < 3000 && !found; c++) begin
         @(negedge clock); #1;
         found = sel ? br.DONE : bh.DONE;
      end
      check({tag, "_done_seen"}, {31'd0, found}, 32'd1);
   endtask

   task automatic check_line(input bit sel, input string tag, input bit hex,
                             input bit crlf, input logic [31:0] d);
      int n_act;
      logic [31:0] act;
      build_expected(hex, crlf, d);
      n_act = sel ? (q_r.size() - base_r) : (q_h.size() - base_h);
      check({tag, "_count"}, 32'(n_act), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         act = 32'hFFFF_FFFF;
         if (i < n_act) act = {24'd0, sel ? q_r[base_r + i] : q_h[base_h + i]};
         check($sformatf("%s_char%0d", tag, i), act, {24'd0, exp_q[i]});
      end
      check({tag, "_done_pulses"}, 32'(sel ? done_r - dbase_r : done_h - dbase_h), 32'd1);
      check({tag, "_txstart_double"}, 32'(sel ? dbl_r : dbl_h), 32'd0);
      check({tag, "_txdata_unstable"}, 32'(sel ? unst_r : unst_h), 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      int          seen;
      bh.START = 1'b0; bh.DATA = '0;
      br.START = 1'b0; br.DATA = '0;

      // Reset state
      repeat (3) @(negedge clock); #1;
      check("rst_busy_h", {31'd0, bh.BUSY}, 32'd0);
      check("rst_done_h", {31'd0, bh.DONE}, 32'd0);
      check("rst_txstart_h", {31'd0, bh.TXSTART}, 32'd0);
      check("rst_txdata_h", {24'd0, bh.TXDATA}, 32'd0);
      check("rst_busy_r", {31'd0, br.BUSY}, 32'd0);
      check("rst_done_r", {31'd0, br.DONE}, 32'd0);
      check("rst_txstart_r", {31'd0, br.TXSTART}, 32'd0);
      check("rst_txdata_r", {24'd0, br.TXDATA}, 32'd0);
      nreset = 1'b1;

      // Hex line with CR LF
      start_line(1'b0, 32'h1234ABCD);
      check("t1_busy_after_start", {31'd0, bh.BUSY}, 32'd1);
      wait_done(1'b0, "t1");
      check_line(1'b0, "t1", 1'b1, 1'b1, 32'h1234ABCD);

      // Raw line, LF only, BUSY drops the cycle after DONE
      start_line(1'b1, 32'h41424344);
      wait_done(1'b1, "t2");
      check_line(1'b1, "t2", 1'b0, 1'b0, 32'h41424344);
      @(negedge clock); #1;
      check("t2_busy_after_done", {31'd0, br.BUSY}, 32'd0);
      check("t2_done_one_cycle", {31'd0, br.DONE}, 32'd0);

      // Random payloads on both variants
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         start_line(1'b0, d);
         wait_done(1'b0, "rnd_h");
         check_line(1'b0, $sformatf("rnd_h%0d", i), 1'b1, 1'b1, d);
         d = $urandom;
         start_line(1'b1, d);
         wait_done(1'b1, "rnd_r");
         check_line(1'b1, $sformatf("rnd_r%0d", i), 1'b0, 1'b0, d);
      end

      // START mid-line is ignored and not queued
      d = $urandom;
      start_line(1'b0, d);
      repeat (45) @(negedge clock); #1;
      bh.START = 1'b1; bh.DATA = 32'hFFFF_FFFF;
      @(negedge clock); #1;
      bh.START = 1'b0;
      wait_done(1'b0, "t3");
      check_line(1'b0, "t3", 1'b1, 1'b1, d);
      repeat (40) @(negedge clock); #1;
      check("t3_no_extra_chars", 32'(q_h.size() - base_h), 32'd10);
      check("t3_idle_busy", {31'd0, bh.BUSY}, 32'd0);

      // TXBUSY held high while in ISSUE
      hold_h = 1'b1;
      d = $urandom;
      start_line(1'b0, d);
      seen = 0;
      repeat (50) begin
         @(negedge clock); #1;
         if (bh.TXSTART) seen++;
      end
      check("t4_no_txstart_while_busy", 32'(seen), 32'd0);
      hold_h = 1'b0;
      @(negedge clock); #1;
      build_expected(1'b1, 1'b1, d);
      check("t4_txstart_after_release", {31'd0, bh.TXSTART}, 32'd1);
      check("t4_first_char", {24'd0, bh.TXDATA}, {24'd0, exp_q[0]});
      wait_done(1'b0, "t4");
      check_line(1'b0, "t4", 1'b1, 1'b1, d);

      // Asynchronous reset after the third character
      start_line(1'b0, 32'hCAFE1234);
      seen = 0;
      for (int c = 0; c < 2000 && (q_h.size() - base_h) < 3; c++) begin
         @(negedge clock); #1;
         seen = c;
      end
      check("t5_three_chars_sent", 32'((q_h.size() - base_h) >= 3), 32'd1);
      repeat (5) @(negedge clock); #1;
      nreset = 1'b0;
      #1;
      check("t5_rst_txstart", {31'd0, bh.TXSTART}, 32'd0);
      check("t5_rst_busy", {31'd0, bh.BUSY}, 32'd0);
      check("t5_rst_done", {31'd0, bh.DONE}, 32'd0);
      check("t5_rst_txdata", {24'd0, bh.TXDATA}, 32'd0);
      repeat (2) @(negedge clock); #1;
      nreset = 1'b1;
      check("t5_no_done_for_aborted", 32'(done_h - dbase_h), 32'd0);
      start_line(1'b0, 32'h0000_0000);
      wait_done(1'b0, "t5");
      check_line(1'b0, "t5", 1'b1, 1'b1, 32'h0000_0000);

      // New START on the edge BUSY drops (still inside the DONE cycle)
      mark(1'b0);
      bh.START = 1'b1; bh.DATA = 32'hDEADBEEF;
      @(negedge clock); #1;
      bh.START = 1'b0;
      check("t6_accepted_busy", {31'd0, bh.BUSY}, 32'd1);
      @(negedge clock); #1;
      check("t6_first_txstart", {31'd0, bh.TXSTART}, 32'd1);
      check("t6_first_txdata", {24'd0, bh.TXDATA}, 32'h44);
      wait_done(1'b0, "t6");
      check_line(1'b0, "t6", 1'b1, 1'b1, 32'hDEADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
